seg_scan_display: RTL



---
 rtl/seg_scan_display.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/seg_scan_display.sv
// Memory-mapped multiplexed 7-segment controller: scans NUM_DIGITS hex digits or
// passes a raw {anodes, segments} word through. Define SEG_SCAN_DISPLAY_DP_EN for DP register.
module seg_scan_display #(
  parameter int          NUM_DIGITS = 4,
  parameter int          SCAN_DIV   = 100000,
  parameter logic [31:0] BASE_ADDR  = 32'h40000010
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           Address,
  input  logic [31:0]           Write_data,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  output logic [31:0]           Read_data,
  output logic [6:0]            leds,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] ans
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int RW = (NUM_DIGITS + 8 > 12) ? NUM_DIGITS + 8 : 12;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] LAST_PRES = PW'(SCAN_DIV - 1);

  typedef enum logic {S_IDLE, S_SCAN} state_t;

  state_t          r_state;
  logic [DW-1:0]   r_data;
  logic [1:0]      r_ctrl;
  logic [RW-1:0]   r_raw;
  logic [PW-1:0]   r_presc;
  logic [IW-1:0]   r_idx;

  logic            w_sel_data, w_sel_ctrl, w_sel_raw;
  logic [3:0]      w_nibble;
  logic [NUM_DIGITS-1:0] w_onehot;
  logic [NUM_DIGITS-1:0] w_blank;
  logic            w_scan_dp, w_raw_dp;
  logic            w_unused;

  assign w_sel_data = (Address == BASE_ADDR);
  assign w_sel_ctrl = (Address == BASE_ADDR + 32'd4);
  assign w_sel_raw  = (Address == BASE_ADDR + 32'd8);
  assign w_nibble   = r_data[{r_idx, 2'b00} +: 4];
  assign w_onehot   = NUM_DIGITS'(1) << r_idx;
  assign w_unused   = &{1'b0, Write_data};

`ifdef SEG_SCAN_DISPLAY_DP_EN
  logic [NUM_DIGITS-1:0] r_dpreg;
  logic                  w_sel_dp;
  assign w_sel_dp  = (Address == BASE_ADDR + 32'd12);
  assign w_scan_dp = ~r_dpreg[r_idx];
  assign w_raw_dp  = ~r_raw[7];

  always_ff @(posedge clk) begin
    if (!reset)                   r_dpreg <= '0;
    else if (MemWrite && w_sel_dp) r_dpreg <= Write_data[NUM_DIGITS-1:0];
  end
`else
  assign w_scan_dp = 1'b1;
  assign w_raw_dp  = 1'b1;
`endif

  // Active-high gfedcba pattern; the output stage inverts it.
  function automatic logic [6:0] hex7seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex7seg = 7'h3F;  4'h1: hex7seg = 7'h06;
      4'h2: hex7seg = 7'h5B;  4'h3: hex7seg = 7'h4F;
      4'h4: hex7seg = 7'h66;  4'h5: hex7seg = 7'h6D;
      4'h6: hex7seg = 7'h7D;  4'h7: hex7seg = 7'h07;
      4'h8: hex7seg = 7'h7F;  4'h9: hex7seg = 7'h6F;
      4'hA: hex7seg = 7'h77;  4'hB: hex7seg = 7'h7C;
      4'hC: hex7seg = 7'h39;  4'hD: hex7seg = 7'h5E;
      4'hE: hex7seg = 7'h79;  default: hex7seg = 7'h71;
    endcase
  endfunction

  // A digit is blanked when it and every more-significant nibble are zero.
  always_comb begin
    logic zero_run;
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    zero_run = 1'b1;
    w_blank  = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run   = zero_run & (r_data[4*k +: 4] == 4'h0);
      w_blank[k] = r_ctrl[1] & zero_run & (k != 0);
    end
  end

  always_comb begin
    Read_data = '0;
    if (MemRead) begin
      if (w_sel_data)      Read_data = 32'(r_data);
      else if (w_sel_ctrl) Read_data = 32'(r_ctrl);
      else if (w_sel_raw)  Read_data = 32'(r_raw);
`ifdef SEG_SCAN_DISPLAY_DP_EN
      else if (w_sel_dp)   Read_data = 32'(r_dpreg);
`endif
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register here samples pre-edge values (reads see the old register contents).
    if (!reset) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_ctrl  <= '0;
      r_raw   <= '0;
      r_presc <= '0;
      r_idx   <= '0;
      leds    <= 7'h7F;
      dp      <= 1'b1;
      ans     <= '1;
    end else begin
      if (MemWrite && w_sel_data) r_data <= Write_data[DW-1:0];
      if (MemWrite && w_sel_ctrl) r_ctrl <= Write_data[1:0];
      if (MemWrite && w_sel_raw)  r_raw  <= Write_data[RW-1:0];

      if (!r_ctrl[0]) begin
        r_state <= S_IDLE;
        r_presc <= '0;
        r_idx   <= '0;
        leds    <= r_raw[6:0];
        ans     <= r_raw[NUM_DIGITS+7:8];
        dp      <= w_raw_dp;
      end else begin
        r_state <= S_SCAN;
        ans     <= ~w_onehot;
        leds    <= w_blank[r_idx] ? 7'h7F : ~hex7seg(w_nibble);
        dp      <= w_scan_dp;
        case (r_state)
          // Counters are held at zero in IDLE, so entry is the first tick of digit 0.
          S_IDLE: begin
            r_presc <= PW'(1);
            r_idx   <= '0;
          end
          default: begin
            if (r_presc == LAST_PRES) begin
              r_presc <= '0;
              r_idx   <= (r_idx == LAST_IDX) ? '0 : r_idx + IW'(1);
            end else begin
              r_presc <= r_presc + PW'(1);
            end
          end
        endcase
      end
    end
  end

endmodule
